// File: rtl/cv32e40p_apu_arb_pkg.sv
// cv32e40p_apu_arb_pkg: shared types and defaults for the cluster APU arbiter
package cv32e40p_apu_arb_pkg;
   localparam int PERF_W_DEF  = 32;
   localparam int ARB_MAX_REQ = 8;
   function automatic int arb_id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
   typedef logic [arb_id_w(ARB_MAX_REQ)-1:0] arb_id_t;
   typedef enum logic {ARB_UNLOCKED, ARB_LOCKED} arb_lock_e;
endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// cv32e40p_apu_core_pkg: APU interface widths shared by the cores and the FPU wrapper
package cv32e40p_apu_core_pkg;
   localparam int APU_NARGS_CPU    = 3;
   localparam int APU_WOP_CPU      = 6;
   localparam int APU_NDSFLAGS_CPU = 15;
   localparam int APU_NUSFLAGS_CPU = 5;
endpackage

// File: rtl/cv32e40p_apu_arb_id_fifo.sv
// cv32e40p_apu_arb_id_fifo: in-order FIFO of requester IDs for outstanding FPU operations
module cv32e40p_apu_arb_id_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 1,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);
   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      mem_d = mem_q;
      if (push_i) mem_d[wp_q] = data_i;
      wp_d  = push_i ? inc(wp_q) : wp_q;
      rp_d  = pop_i ? inc(rp_q) : rp_q;
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   assign data_o  = mem_q[rp_q];
   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// cv32e40p_apu_arbiter: round-robin share of one FPU among NUM_REQ cores, in-order response routing.
// Define CV32E40P_APU_ARB_PERF_EN to add per-core saturating issue/stall counters.
module cv32e40p_apu_arbiter
   import cv32e40p_apu_arb_pkg::*;
   import cv32e40p_apu_core_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DEPTH   = 4
`ifdef CV32E40P_APU_ARB_PERF_EN
   ,parameter int PERF_W = PERF_W_DEF
`endif
) (
   input  logic                                               clk_i,
   input  logic                                               rst_ni,
   input  logic [NUM_REQ-1:0]                                 req_apu_req_i,
   output logic [NUM_REQ-1:0]                                 req_apu_gnt_o,
   input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]        req_apu_operands_i,
   input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]                req_apu_op_i,
   input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]           req_apu_flags_i,
   output logic [NUM_REQ-1:0]                                 req_apu_rvalid_o,
   output logic [31:0]                                        req_apu_rdata_o,
   output logic [APU_NUSFLAGS_CPU-1:0]                        req_apu_rflags_o,
   output logic                                               fpu_req_o,
   input  logic                                               fpu_gnt_i,
   output logic [APU_NARGS_CPU-1:0][31:0]                     fpu_operands_o,
   output logic [APU_WOP_CPU-1:0]                             fpu_op_o,
   output logic [APU_NDSFLAGS_CPU-1:0]                        fpu_flags_o,
   input  logic                                               fpu_rvalid_i,
   input  logic [31:0]                                        fpu_rdata_i,
   input  logic [APU_NUSFLAGS_CPU-1:0]                        fpu_rflags_i,
   output logic                                               busy_o,
   output logic                                               spurious_rsp_o
`ifdef CV32E40P_APU_ARB_PERF_EN
   ,output logic [NUM_REQ-1:0][PERF_W-1:0]                    perf_issue_o,
   output logic [NUM_REQ-1:0][PERF_W-1:0]                     perf_stall_o
`endif
);
   localparam int IDW = arb_id_w(NUM_REQ);
   localparam int CW  = $clog2(DEPTH + 1);

   arb_lock_e      lock_q, lock_d;
   logic [IDW-1:0] win, win_rr, win_q, win_d, rr_q, rr_d, head;
   logic           full, empty, issue, pop, spur_q, spur_d;
   logic [CW-1:0]  count;

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
      int k;
      k = int'(base) + off;
      return IDW'((k >= NUM_REQ) ? k - NUM_REQ : k);
   endfunction

   // Downward scan so the last hit is the first requester at or above rr_q.
   always_comb begin
      win_rr = rr_q;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_apu_req_i[rr_idx(rr_q, i)]) win_rr = rr_idx(rr_q, i);
      win = (lock_q == ARB_LOCKED) ? win_q : win_rr;
   end

   always_comb begin
      fpu_req_o        = |req_apu_req_i & ~full;
      issue            = fpu_req_o & fpu_gnt_i;
      pop              = fpu_rvalid_i & ~empty;
      fpu_operands_o   = fpu_req_o ? req_apu_operands_i[win] : '0;
      fpu_op_o         = fpu_req_o ? req_apu_op_i[win] : '0;
      fpu_flags_o      = fpu_req_o ? req_apu_flags_i[win] : '0;
      req_apu_gnt_o    = '0;
      req_apu_gnt_o[win] = issue;
      req_apu_rvalid_o = '0;
      req_apu_rvalid_o[head] = pop;
      lock_d           = issue ? ARB_UNLOCKED : (fpu_req_o ? ARB_LOCKED : lock_q);
      win_d            = fpu_req_o ? win : win_q;
      rr_d             = issue ? rr_idx(win, 1) : rr_q;
      spur_d           = spur_q | (fpu_rvalid_i & empty);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q <= ARB_UNLOCKED;
         win_q  <= '0;
         rr_q   <= '0;
         spur_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
         win_q  <= win_d;
         rr_q   <= rr_d;
         spur_q <= spur_d;
      end
   end

   cv32e40p_apu_arb_id_fifo #(.DEPTH(DEPTH), .W(IDW)) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (issue),
      .data_i  (win),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   assign req_apu_rdata_o  = fpu_rdata_i;
   assign req_apu_rflags_o = fpu_rflags_i;
   assign busy_o           = |count;
   assign spurious_rsp_o   = spur_q;

`ifdef CV32E40P_APU_ARB_PERF_EN
   logic [NUM_REQ-1:0][PERF_W-1:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         perf_issue_d[i] = perf_issue_q[i] + PERF_W'(req_apu_gnt_o[i] & ~&perf_issue_q[i]);
         perf_stall_d[i] = perf_stall_q[i] + PERF_W'(req_apu_req_i[i] & ~req_apu_gnt_o[i] & ~&perf_stall_q[i]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_issue_q <= perf_issue_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_issue_o = perf_issue_q;
   assign perf_stall_o = perf_stall_q;
`endif
endmodule
